// File: rtl/fp32_pkg.sv
// Shared definitions for the FP32 adder arbiter and later shared-FPU arbiters.
package fp32_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

  localparam logic [31:0] FP32_QNAN = 32'h7fc00000;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam logic [1:0] RM_RNE = 2'd0;
  localparam logic [1:0] RM_RTZ = 2'd1;
  localparam logic [1:0] RM_RDN = 2'd2;
  localparam logic [1:0] RM_RUP = 2'd3;

endpackage

// File: rtl/fp32_adder_arbiter_rr_pick.sv
// Combinational rotate-priority picker: first set request at or above ptr_i, wrapping.
module rr_pick #(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = $clog2(N)
) (
  input  logic [N-1:0]   req_i,
  input  logic [IDW-1:0] ptr_i,
  output logic           any_o,
  output logic [N-1:0]   gnt_o,
  output logic [IDW-1:0] idx_o
);

  logic [N-1:0] rot;

  always_comb begin
    // rot[p] is the request that sits p places above the pointer
    rot   = N'({req_i, req_i} >> ptr_i);
    any_o = 1'b0;
    idx_o = '0;
    gnt_o = '0;
    for (int unsigned p = 0; p < N; p++) begin
      if (!any_o && rot[p]) begin
        any_o = 1'b1;
        idx_o = IDW'((p + 32'(ptr_i)) % N);
      end
    end
    for (int unsigned j = 0; j < N; j++) begin
      gnt_o[j] = any_o && (idx_o == IDW'(j));
    end
  end

endmodule

// File: rtl/fp32_adder_arbiter.sv
// Round-robin sharing of one fp32_adder among NREQ requesters, with a watchdog
// that answers with a quiet NaN and rsp_err if the adder never returns valid.
module fp32_adder_arbiter
  import fp32_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned IDW     = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*32-1:0]   req_a,
  input  logic [NREQ*32-1:0]   req_b,
  input  logic [NREQ*2-1:0]    req_rm,
  input  logic [NREQ-1:0]      req_sel,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [31:0]          rsp_data,
  output logic                 rsp_err,
  output logic [IDW-1:0]       grant_id,
  output logic                 busy,
  output logic                 add_ena,
  output logic [31:0]          add_a,
  output logic [31:0]          add_b,
  output logic [1:0]           add_rm,
  output logic                 add_sel,
  input  logic [31:0]          add_s,
  input  logic                 add_valid
);

  localparam int unsigned TW = $clog2(TIMEOUT);

  arb_state_e     state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] grant_id_q, grant_id_d;
  logic [31:0]    a_q, a_d, b_q, b_d;
  logic [1:0]     rm_q, rm_d;
  logic           sel_q, sel_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [31:0]    rsp_data_q, rsp_data_d;
  logic           rsp_err_q, rsp_err_d;

  logic            pick_any;
  logic [NREQ-1:0] pick_gnt;
  logic [IDW-1:0]  pick_idx;
  logic            owner_ready;

  rr_pick #(
    .N   (NREQ),
    .IDW (IDW)
  ) u_pick (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .any_o (pick_any),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx)
  );

  // Only the current owner sees rsp_valid, and only its rsp_ready counts.
  always_comb begin
    rsp_valid   = '0;
    owner_ready = 1'b0;
    if (state_q == ST_RESP) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (grant_id_q == IDW'(i)) begin
          rsp_valid[i] = 1'b1;
          owner_ready  = rsp_ready[i];
        end
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    a_d        = a_q;
    b_d        = b_q;
    rm_d       = rm_q;
    sel_d      = sel_q;
    timer_d    = timer_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          for (int unsigned i = 0; i < NREQ; i++) begin
            if (pick_gnt[i]) begin
              a_d   = req_a[32*i +: 32];
              b_d   = req_b[32*i +: 32];
              rm_d  = req_rm[2*i +: 2];
              sel_d = req_sel[i];
            end
          end
          grant_id_d = pick_idx;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        timer_d = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A valid arriving on the expiry cycle still wins over the timeout.
        if (add_valid) begin
          rsp_data_d = add_s;
          rsp_err_d  = 1'b0;
          state_d    = ST_RESP;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          rsp_data_d = FP32_QNAN;
          rsp_err_d  = 1'b1;
          state_d    = ST_RESP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_RESP: begin
        if (owner_ready) begin
          rr_ptr_d = (grant_id_q == IDW'(NREQ - 1)) ? '0 : grant_id_q + 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      a_q        <= '0;
      b_q        <= '0;
      rm_q       <= '0;
      sel_q      <= 1'b0;
      timer_q    <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      a_q        <= a_d;
      b_q        <= b_d;
      rm_q       <= rm_d;
      sel_q      <= sel_d;
      timer_q    <= timer_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  // req_ready is gated by rstn so every output reads 0 while reset is held.
  assign req_ready = (rstn && state_q == ST_IDLE) ? pick_gnt : '0;
  assign busy      = (state_q != ST_IDLE);
  assign add_ena   = (state_q == ST_ISSUE);
  assign grant_id  = grant_id_q;
  assign add_a     = a_q;
  assign add_b     = b_q;
  assign add_rm    = rm_q;
  assign add_sel   = sel_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_fp32_adder_arbiter.sv
// Directed bench for fp32_adder_arbiter with a table-driven adder stub.
module tb_fp32_adder_arbiter;

  localparam int unsigned NREQ    = 4;
  localparam int unsigned TIMEOUT = 8;
  localparam int unsigned IDW     = 2;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic [NREQ-1:0]    req_valid = '0, req_sel = '0, rsp_ready = '0;
  logic [NREQ-1:0]    req_ready, rsp_valid;
  logic [NREQ*32-1:0] req_a = '0, req_b = '0;
  logic [NREQ*2-1:0]  req_rm = '0;
  logic [31:0]        rsp_data, add_a, add_b, add_s;
  logic               rsp_err, busy, add_ena, add_sel, add_valid;
  logic [IDW-1:0]     grant_id;
  logic [1:0]         add_rm;

  int checks = 0;
  int errors = 0;

  logic        stub_on = 1'b1;
  int          stub_lat = 2;
  logic        man_valid = 1'b0;
  logic        stub_valid;
  logic [31:0] stub_s;
  logic        pend;
  int          cnt;
  int          ena_cnt = 0;

  fp32_adder_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_rm(req_rm), .req_sel(req_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .grant_id(grant_id), .busy(busy),
    .add_ena(add_ena), .add_a(add_a), .add_b(add_b), .add_rm(add_rm),
    .add_sel(add_sel), .add_s(add_s), .add_valid(add_valid)
  );

  always #5 clk = ~clk;

  // Hand-computed sums for the known vectors; other operands get an a^b tag.
  function automatic logic [31:0] ref_sum(input logic [31:0] a, input logic [31:0] b,
                                          input logic sel);
    if (a == 32'h40000000 && b == 32'h40400000 && sel == 1'b0) return 32'h40a00000;
    if (a == 32'h40b00000 && b == 32'h3fc00000 && sel == 1'b1) return 32'h40800000;
    if (a == 32'h40400000 && b == 32'hc0100000 && sel == 1'b0) return 32'h3f400000;
    return a ^ b;
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend       <= 1'b0;
      stub_valid <= 1'b0;
      cnt        <= 0;
      stub_s     <= '0;
    end else begin
      stub_valid <= 1'b0;
      if (add_ena && stub_on) begin
        stub_s <= ref_sum(add_a, add_b, add_sel);
        if (stub_lat <= 1) stub_valid <= 1'b1;
        else begin
          pend <= 1'b1;
          cnt  <= stub_lat - 2;
        end
      end else if (pend) begin
        if (cnt == 0) begin
          pend       <= 1'b0;
          stub_valid <= 1'b1;
        end else cnt <= cnt - 1;
      end
    end
  end

  assign add_valid = stub_valid | man_valid;
  assign add_s     = stub_s;

  always @(posedge clk) if (add_ena) ena_cnt <= ena_cnt + 1;

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] rm, input logic sel);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
    req_rm[2*i +: 2]  = rm;
    req_sel[i]        = sel;
    req_valid[i]      = 1'b1;
  endtask

  task automatic clr_req(input int i);
    req_valid[i] = 1'b0;
  endtask

  // Returns the number of negedges until rsp_valid rises, or -1 on expiry.
  task automatic wait_rsp(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (|rsp_valid) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || add_ena !== 1'b0 || req_ready !== 4'b0 || rsp_valid !== 4'b0) begin
      errors++;
      $display("FAIL reset_ctrl busy=%b ena=%b rdy=%b rv=%b exp all 0", busy, add_ena, req_ready, rsp_valid);
    end
    checks++;
    if (add_a !== 32'h0 || add_b !== 32'h0 || add_rm !== 2'b0 || add_sel !== 1'b0 ||
        rsp_data !== 32'h0 || rsp_err !== 1'b0 || grant_id !== 2'd0) begin
      errors++;
      $display("FAIL reset_data a=%h b=%h rm=%b sel=%b d=%h err=%b gid=%0d exp all 0",
               add_a, add_b, add_rm, add_sel, rsp_data, rsp_err, grant_id);
    end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int cyc, e0;
    @(negedge clk);
    set_req(0, 32'h40000000, 32'h40400000, 2'd0, 1'b0);
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++; $display("FAIL basic_ready got %b exp 0001", req_ready);
    end
    e0 = ena_cnt;
    @(negedge clk);
    clr_req(0);
    checks++;
    if (add_ena !== 1'b1 || add_a !== 32'h40000000 || add_b !== 32'h40400000 || grant_id !== 2'd0) begin
      errors++;
      $display("FAIL basic_issue ena=%b a=%h b=%h gid=%0d exp 1 40000000 40400000 0", add_ena, add_a, add_b, grant_id);
    end
    wait_rsp(cyc);
    checks++;
    if (cyc != 1 + stub_lat) begin
      errors++; $display("FAIL basic_latency got %0d exp %0d", cyc, 1 + stub_lat);
    end
    checks++;
    if (rsp_valid !== 4'b0001 || rsp_data !== 32'h40a00000 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL basic_rsp rv=%b d=%h err=%b exp 0001 40a00000 0", rsp_valid, rsp_data, rsp_err);
    end
    checks++;
    if (ena_cnt - e0 != 1) begin
      errors++; $display("FAIL basic_ena_count got %0d exp 1", ena_cnt - e0);
    end
    rsp_ready = 4'b0001;
    @(negedge clk);
    rsp_ready = '0;
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 4'b0) begin
      errors++; $display("FAIL basic_done busy=%b rv=%b exp 0 0000", busy, rsp_valid);
    end
  endtask

  task automatic test_pair();
    int cyc;
    @(negedge clk);
    set_req(1, 32'h40b00000, 32'h3fc00000, 2'd0, 1'b1);
    set_req(3, 32'h40400000, 32'hc0100000, 2'd0, 1'b0);
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++; $display("FAIL pair_ready1 got %b exp 0010", req_ready);
    end
    @(negedge clk);
    clr_req(1);
    checks++;
    if (grant_id !== 2'd1 || add_sel !== 1'b1 || add_a !== 32'h40b00000) begin
      errors++; $display("FAIL pair_issue1 gid=%0d sel=%b a=%h exp 1 1 40b00000", grant_id, add_sel, add_a);
    end
    wait_rsp(cyc);
    checks++;
    if (cyc < 0 || rsp_valid !== 4'b0010 || rsp_data !== 32'h40800000 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL pair_rsp1 cyc=%0d rv=%b d=%h err=%b exp 0010 40800000 0", cyc, rsp_valid, rsp_data, rsp_err);
    end
    rsp_ready = 4'b0010;
    @(negedge clk);
    rsp_ready = '0;
    #1;
    checks++;
    if (req_ready !== 4'b1000) begin
      errors++; $display("FAIL pair_ready3 got %b exp 1000", req_ready);
    end
    @(negedge clk);
    clr_req(3);
    checks++;
    if (grant_id !== 2'd3 || add_a !== 32'h40400000 || add_b !== 32'hc0100000 || add_sel !== 1'b0) begin
      errors++;
      $display("FAIL pair_issue3 gid=%0d a=%h b=%h sel=%b exp 3 40400000 c0100000 0", grant_id, add_a, add_b, add_sel);
    end
    wait_rsp(cyc);
    checks++;
    if (cyc < 0 || rsp_valid !== 4'b1000 || rsp_data !== 32'h3f400000) begin
      errors++; $display("FAIL pair_rsp3 cyc=%0d rv=%b d=%h exp 1000 3f400000", cyc, rsp_valid, rsp_data);
    end
    rsp_ready = 4'b1000;
    @(negedge clk);
    rsp_ready = '0;
  endtask

  task automatic test_fairness();
    int cyc, e0, w;
    logic [31:0] fa[NREQ];
    logic [31:0] fb[NREQ];
    logic [NREQ-1:0] exp_oh;
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      fa[i] = 32'h3f800000 + i;
      fb[i] = 32'h00010000 << i;
      set_req(i, fa[i], fb[i], 2'd1, 1'b0);
    end
    rsp_ready = '1;
    e0 = ena_cnt;
    for (int op = 0; op < 8; op++) begin
      #1;
      w = op % NREQ;
      exp_oh = 4'b0001 << w;
      checks++;
      if (req_ready !== exp_oh) begin
        errors++; $display("FAIL fair_grant op=%0d got %b exp %b", op, req_ready, exp_oh);
      end
      wait_rsp(cyc);
      checks++;
      if (cyc < 0 || rsp_valid !== exp_oh || rsp_data !== (fa[w] ^ fb[w])) begin
        errors++;
        $display("FAIL fair_rsp op=%0d rv=%b d=%h exp %b %h", op, rsp_valid, rsp_data, exp_oh, fa[w] ^ fb[w]);
      end
      @(negedge clk);
    end
    req_valid = '0;
    rsp_ready = '0;
    checks++;
    if (ena_cnt - e0 != 8) begin
      errors++; $display("FAIL fair_ena_count got %0d exp 8", ena_cnt - e0);
    end
  endtask

  task automatic test_timeout();
    int cyc;
    logic bad;
    stub_on = 1'b0;
    @(negedge clk);
    set_req(0, 32'h40000000, 32'h3f800000, 2'd0, 1'b0);
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++; $display("FAIL to_ready got %b exp 0001", req_ready);
    end
    @(negedge clk);
    clr_req(0);
    checks++;
    if (add_ena !== 1'b1) begin
      errors++; $display("FAIL to_issue ena=%b exp 1", add_ena);
    end
    wait_rsp(cyc);
    checks++;
    if (cyc != TIMEOUT + 1) begin
      errors++; $display("FAIL to_latency got %0d exp %0d", cyc, TIMEOUT + 1);
    end
    checks++;
    if (rsp_valid !== 4'b0001 || rsp_err !== 1'b1 || rsp_data !== 32'h7fc00000) begin
      errors++;
      $display("FAIL to_rsp rv=%b err=%b d=%h exp 0001 1 7fc00000", rsp_valid, rsp_err, rsp_data);
    end
    man_valid = 1'b1;
    @(negedge clk);
    man_valid = 1'b0;
    checks++;
    if (rsp_valid !== 4'b0001 || rsp_err !== 1'b1 || rsp_data !== 32'h7fc00000) begin
      errors++;
      $display("FAIL to_late_in_resp rv=%b err=%b d=%h exp 0001 1 7fc00000", rsp_valid, rsp_err, rsp_data);
    end
    rsp_ready = 4'b0001;
    @(negedge clk);
    rsp_ready = '0;
    man_valid = 1'b1;
    @(negedge clk);
    man_valid = 1'b0;
    bad = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (rsp_valid !== 4'b0 || busy !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL to_no_second_rsp rv=%b busy=%b exp 0000 0", rsp_valid, busy);
    end
    stub_on = 1'b1;
  endtask

  task automatic test_hold();
    int cyc;
    @(negedge clk);
    set_req(2, 32'h40000000, 32'h40400000, 2'd0, 1'b0);
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++; $display("FAIL hold_ready2 got %b exp 0100", req_ready);
    end
    @(negedge clk);
    clr_req(2);
    wait_rsp(cyc);
    checks++;
    if (cyc < 0 || rsp_valid !== 4'b0100 || rsp_data !== 32'h40a00000) begin
      errors++; $display("FAIL hold_rsp2 cyc=%0d rv=%b d=%h exp 0100 40a00000", cyc, rsp_valid, rsp_data);
    end
    set_req(0, 32'h40b00000, 32'h3fc00000, 2'd0, 1'b1);
    rsp_ready = 4'b1011;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      #1;
      checks++;
      if (rsp_valid !== 4'b0100 || rsp_data !== 32'h40a00000 || req_ready !== 4'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL hold_stable k=%0d rv=%b d=%h rdy=%b busy=%b exp 0100 40a00000 0000 1",
                 k, rsp_valid, rsp_data, req_ready, busy);
      end
    end
    @(negedge clk);
    rsp_ready = 4'b0100;
    @(negedge clk);
    rsp_ready = '0;
    #1;
    checks++;
    if (req_ready !== 4'b0001 || rsp_valid !== 4'b0) begin
      errors++; $display("FAIL hold_ready0 rdy=%b rv=%b exp 0001 0000", req_ready, rsp_valid);
    end
    @(negedge clk);
    clr_req(0);
    checks++;
    if (grant_id !== 2'd0 || add_sel !== 1'b1) begin
      errors++; $display("FAIL hold_issue0 gid=%0d sel=%b exp 0 1", grant_id, add_sel);
    end
    wait_rsp(cyc);
    checks++;
    if (cyc < 0 || rsp_valid !== 4'b0001 || rsp_data !== 32'h40800000) begin
      errors++; $display("FAIL hold_rsp0 cyc=%0d rv=%b d=%h exp 0001 40800000", cyc, rsp_valid, rsp_data);
    end
    rsp_ready = 4'b0001;
    @(negedge clk);
    rsp_ready = '0;
  endtask

  task automatic test_reset_wait();
    int cyc;
    stub_on = 1'b0;
    @(negedge clk);
    set_req(3, 32'h12345678, 32'h9abcdef0, 2'd3, 1'b1);
    #1;
    checks++;
    if (req_ready !== 4'b1000) begin
      errors++; $display("FAIL rw_ready3 got %b exp 1000", req_ready);
    end
    @(negedge clk);
    clr_req(3);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || grant_id !== 2'd3 || add_a !== 32'h12345678 || add_rm !== 2'd3) begin
      errors++;
      $display("FAIL rw_in_wait busy=%b gid=%0d a=%h rm=%0d exp 1 3 12345678 3", busy, grant_id, add_a, add_rm);
    end
    #2 rstn = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || grant_id !== 2'd0 || add_a !== 32'h0 || add_b !== 32'h0 || add_rm !== 2'b0 ||
        add_sel !== 1'b0 || rsp_data !== 32'h0 || rsp_err !== 1'b0 || rsp_valid !== 4'b0 ||
        add_ena !== 1'b0 || req_ready !== 4'b0) begin
      errors++;
      $display("FAIL rw_async_reset busy=%b gid=%0d a=%h b=%h rm=%b sel=%b d=%h err=%b rv=%b ena=%b rdy=%b exp all 0",
               busy, grant_id, add_a, add_b, add_rm, add_sel, rsp_data, rsp_err, rsp_valid, add_ena, req_ready);
    end
    @(negedge clk);
    rstn = 1'b1;
    stub_on = 1'b1;
    @(negedge clk);
    set_req(0, 32'h40000000, 32'h40400000, 2'd0, 1'b0);
    set_req(2, 32'h40b00000, 32'h3fc00000, 2'd0, 1'b1);
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++; $display("FAIL rw_ptr_reset got %b exp 0001", req_ready);
    end
    @(negedge clk);
    clr_req(0);
    wait_rsp(cyc);
    checks++;
    if (cyc < 0 || rsp_valid !== 4'b0001 || rsp_data !== 32'h40a00000) begin
      errors++; $display("FAIL rw_rsp0 cyc=%0d rv=%b d=%h exp 0001 40a00000", cyc, rsp_valid, rsp_data);
    end
    rsp_ready = 4'b0001;
    @(negedge clk);
    rsp_ready = '0;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++; $display("FAIL rw_ready2 got %b exp 0100", req_ready);
    end
    @(negedge clk);
    clr_req(2);
    checks++;
    if (grant_id !== 2'd2 || add_ena !== 1'b1) begin
      errors++; $display("FAIL rw_issue2 gid=%0d ena=%b exp 2 1", grant_id, add_ena);
    end
    wait_rsp(cyc);
    checks++;
    if (cyc != 1 + stub_lat || rsp_valid !== 4'b0100 || rsp_data !== 32'h40800000 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL rw_rsp2 cyc=%0d rv=%b d=%h err=%b exp %0d 0100 40800000 0",
               cyc, rsp_valid, rsp_data, rsp_err, 1 + stub_lat);
    end
    rsp_ready = 4'b0100;
    @(negedge clk);
    rsp_ready = '0;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL rw_idle busy=%b exp 0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pair();
    test_fairness();
    test_timeout();
    test_hold();
    test_reset_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not complete");
    $fatal(1);
  end

endmodule
